fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the MEM-stage forward/stall unit. Resolves GPR and CSR data hazards for NUM_RS GPR read ports plus one CSR port, across the MEM and WB producers.
- Replaces combinational load-data forwarding with a registered load-use FSM. The load holds in MEM, returned data is captured in a hold register, and it is forwarded on the release cycle. This takes MEM_o_rdata out of the EXU operand path.
- Adds a stall-timeout watchdog and a flush abort. Sits beside the MEM stage and drives the stall/bubble inputs of all segment registers.

Parameters:
- XLEN, 32, data width.
- GPR_AW, 5, GPR index width; index 0 is hard-wired zero and never forwarded.
- CSR_AW, 2, CSR compressed index width.
- NUM_RS, 2, number of GPR read ports per stage (1..3).
- TMO_W, 8, watchdog counter width; timeout at 2^TMO_W-1 consecutive stall cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- IFU_o_valid, MEM_rvalid, MEM_wready  in  1 each  bus readiness.
- flush_i  in  1  redirect from EXU/trap; aborts any pending load-use wait.
- IDU_o_rs  in  NUM_RS*GPR_AW  IDU source indices, packed port 0 at LSB.
- IDU_o_csr_rs  in  CSR_AW  IDU CSR source index.
- EXU_o_rs  in  NUM_RS*GPR_AW  EXU source indices, packed port 0 at LSB.
- EXU_o_csr_rs  in  CSR_AW  EXU CSR source index.
- MEM_i_rd, MEM_i_csr_rd, MEM_i_write_gpr, MEM_i_write_csr, MEM_i_mem_to_reg  in  GPR_AW/CSR_AW/1/1/1  MEM producer.
- MEM_i_ALU_ALUout, MEM_i_ALU_CSR_out, MEM_o_rdata  in  XLEN each  MEM producer data.
- WB_o_rd, WB_o_csr_rd, WB_o_write_gpr, WB_o_write_csr  in  GPR_AW/CSR_AW/1/1  WB producer.
- WB_o_rd_data, WB_o_csr_data  in  XLEN  WB producer data.
- FORWARD_stallIF/ID/EX/ME/WB  out  1 each  segment-register hold.
- FORWARD_bubbleWB  out  1  insert NOP into MEM->WB register.
- FORWARD_rs_hazard_EXU  out  NUM_RS  per-port forward select, EXU.
- FORWARD_rs_data_EXU  out  NUM_RS*XLEN  forwarded operands, EXU.
- FORWARD_csr_hazard_EXU  out  1  CSR forward select, EXU.
- FORWARD_csr_data_EXU  out  XLEN  forwarded CSR operand, EXU.
- FORWARD_rs_hazard_SEG  out  NUM_RS  per-port forward select, ID/EX register.
- FORWARD_rs_data_SEG  out  NUM_RS*XLEN  WB-to-ID/EX forwarded operands.
- FORWARD_csr_hazard_SEG  out  1  CSR forward select, ID/EX register.
- FORWARD_csr_data_SEG  out  XLEN  WB-to-ID/EX forwarded CSR operand.
- FORWARD_tmo_err  out  1  sticky watchdog error.

Behaviour:
- Reset: state=RUN, hold_data=0, hold_rd=0, tmo_cnt=0, FORWARD_tmo_err=0. All data outputs are 0 when their select is 0.
- Hit definitions:
  - mem_hit[i]: EXU rs[i]==MEM_i_rd & MEM_i_write_gpr & rd!=0.
  - wb_hit[i]: EXU rs[i]==WB_o_rd & WB_o_write_gpr & rd!=0.
  - seg_hit[i]: IDU rs[i]==WB_o_rd & WB_o_write_gpr & rd!=0.
  - CSR hits are the same but with no x0 exclusion.
- bus_ok = IFU_o_valid & MEM_wready & (MEM_rvalid | ~MEM_i_mem_to_reg).
- lu = any mem_hit (or CSR MEM hit) with MEM_i_mem_to_reg=1.
- FSM RUN:
  - ALU hit forwards MEM ALUout/CSR_out; this has priority over WB.
  - If lu & ~flush_i: next state LU_WAIT, all stalls=1.
  - Else all stalls = ~bus_ok.
- FSM LU_WAIT:
  - All stalls=1.
  - On MEM_rvalid: hold_data<=MEM_o_rdata, hold_rd<=MEM_i_rd, next state LU_FWD.
- FSM LU_FWD (1 cycle):
  - Stalls = ~(IFU_o_valid & MEM_wready).
  - Ports with EXU rs==hold_rd forward hold_data, priority over WB (the load is now in WB).
  - If the stall holds, stay in LU_FWD; else next state RUN.
- Load-use penalty = wait cycles + 1.
- flush_i in any state: next state RUN, hold_rd<=0 (hold invalid), FORWARD_bubbleWB=1 only if leaving LU_WAIT without data.
- Forward priority per port: hold(LU_FWD) > MEM ALU > WB.
- SEG path: seg_hit forwards WB data only.
- Watchdog:
  - tmo_cnt increments each cycle FORWARD_stallIF=1 and clears otherwise.
  - Saturates at all-ones, which sets FORWARD_tmo_err (sticky until reset).
  - Stalling continues after the error.
- Asynchronous reset mid-LU_WAIT returns to RUN immediately and clears the hold.

Optional Feature:
- FWD_PERF_CNT_EN defined: adds 32-bit outputs FORWARD_perf_lu_cnt (LU_WAIT entries) and FORWARD_perf_stall_cnt (stall cycles). Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds:
  - fsm enum fwd_state_e {RUN, LU_WAIT, LU_FWD};
  - XLEN/GPR_AW/CSR_AW defaults;
  - REG_X0 constant.
- One sub-module, fwd_port_sel: per-port comparator and priority mux, instantiated NUM_RS times plus once for CSR.

Test Plan:
- ALU chain: MEM rd=5 write_gpr, ALUout=0x1234; EXU rs0=5 -> hazard_EXU[0]=1, data=0x1234, no stall.
- Load-use: MEM load rd=7, EXU rs1=7, rvalid after 3 cycles with 0xDEADBEEF -> 3 stall cycles in LU_WAIT, then in LU_FWD data_EXU[1]=0xDEADBEEF and stall=0.
- Priority: MEM rd=3 ALU 0xA, WB rd=3 0xB, EXU rs0=3 -> data 0xA; with MEM rd=0 -> no MEM hit, data 0xB.
- Flush in LU_WAIT: flush_i at wait cycle 2 -> next cycle RUN, bubbleWB=1, no forwarding of hold.
- Watchdog: TMO_W=4, IFU_o_valid=0 for 15 cycles -> tmo_err=1 on cycle 15 and stays 1 after IFU_o_valid=1.
- SEG path: WB rd=9 0x55, IDU rs0=9 -> hazard_SEG[0]=1, data_SEG=0x55; WB rd=0 -> 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and default widths for the forward/hazard unit.
package fwd_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned GPR_AW_DEF = 5;
  localparam int unsigned CSR_AW_DEF = 2;
  localparam int unsigned NUM_RS_DEF = 2;
  localparam int unsigned TMO_W_DEF  = 8;

  // GPR index that reads as constant zero and is never a forwarding target
  localparam int unsigned REG_X0 = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    LU_FWD  = 2'd2
  } fwd_state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// One operand port: compares its source index against the hold/MEM/WB
// producers and selects the forwarded value (hold > MEM ALU > WB).
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int unsigned AW      = GPR_AW_DEF,
  parameter int unsigned DW      = XLEN_DEF,
  parameter bit          X0_EXCL = 1'b1
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic          mem_ld,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_data,
  input  logic          hold_en,
  input  logic [AW-1:0] hold_rd,
  input  logic [DW-1:0] hold_data,
  output logic          ld_hit_c,
  output logic          sel_c,
  output logic [DW-1:0] data_c
);

  logic rs_live;
  logic mem_hit;
  logic wb_hit;
  logic hold_hit;

  // rs==rd on a hit, so excluding rs==x0 excludes rd==x0 as well
  assign rs_live  = !X0_EXCL || (rs != AW'(REG_X0));
  assign mem_hit  = rs_live && mem_we && (rs == mem_rd);
  assign wb_hit   = rs_live && wb_we && (rs == wb_rd);
  assign hold_hit = rs_live && hold_en && (rs == hold_rd);
  assign ld_hit_c = mem_hit && mem_ld;

  always_comb begin
    sel_c  = 1'b0;
    data_c = '0;
    if (hold_hit) begin
      sel_c  = 1'b1;
      data_c = hold_data;
    end else if (mem_hit && !mem_ld) begin
      sel_c  = 1'b1;
      data_c = mem_data;
    end else if (wb_hit) begin
      sel_c  = 1'b1;
      data_c = wb_data;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// GPR/CSR forwarding and stall control beside MEM, with a registered
// load-use FSM and stall watchdog. Define FWD_PERF_CNT_EN for perf counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned GPR_AW = GPR_AW_DEF,
  parameter int unsigned CSR_AW = CSR_AW_DEF,
  parameter int unsigned NUM_RS = NUM_RS_DEF,
  parameter int unsigned TMO_W  = TMO_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     IFU_o_valid,
  input  logic                     MEM_rvalid,
  input  logic                     MEM_wready,
  input  logic                     flush_i,
  input  logic [NUM_RS*GPR_AW-1:0] IDU_o_rs,
  input  logic [CSR_AW-1:0]        IDU_o_csr_rs,
  input  logic [NUM_RS*GPR_AW-1:0] EXU_o_rs,
  input  logic [CSR_AW-1:0]        EXU_o_csr_rs,
  input  logic [GPR_AW-1:0]        MEM_i_rd,
  input  logic [CSR_AW-1:0]        MEM_i_csr_rd,
  input  logic                     MEM_i_write_gpr,
  input  logic                     MEM_i_write_csr,
  input  logic                     MEM_i_mem_to_reg,
  input  logic [XLEN-1:0]          MEM_i_ALU_ALUout,
  input  logic [XLEN-1:0]          MEM_i_ALU_CSR_out,
  input  logic [XLEN-1:0]          MEM_o_rdata,
  input  logic [GPR_AW-1:0]        WB_o_rd,
  input  logic [CSR_AW-1:0]        WB_o_csr_rd,
  input  logic                     WB_o_write_gpr,
  input  logic                     WB_o_write_csr,
  input  logic [XLEN-1:0]          WB_o_rd_data,
  input  logic [XLEN-1:0]          WB_o_csr_data,
  output logic                     FORWARD_stallIF,
  output logic                     FORWARD_stallID,
  output logic                     FORWARD_stallEX,
  output logic                     FORWARD_stallME,
  output logic                     FORWARD_stallWB,
  output logic                     FORWARD_bubbleWB,
  output logic [NUM_RS-1:0]        FORWARD_rs_hazard_EXU,
  output logic [NUM_RS*XLEN-1:0]   FORWARD_rs_data_EXU,
  output logic                     FORWARD_csr_hazard_EXU,
  output logic [XLEN-1:0]          FORWARD_csr_data_EXU,
  output logic [NUM_RS-1:0]        FORWARD_rs_hazard_SEG,
  output logic [NUM_RS*XLEN-1:0]   FORWARD_rs_data_SEG,
  output logic                     FORWARD_csr_hazard_SEG,
  output logic [XLEN-1:0]          FORWARD_csr_data_SEG,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]              FORWARD_perf_lu_cnt,
  output logic [31:0]              FORWARD_perf_stall_cnt,
`endif
  output logic                     FORWARD_tmo_err
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  fwd_state_e        state_q, state_d;
  logic [XLEN-1:0]   hold_data_q;
  logic [GPR_AW-1:0] hold_rd_q;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              tmo_err_q;

  logic [NUM_RS-1:0] ld_hit;
  logic              csr_ld_hit;
  logic              lu;
  logic              bus_ok;
  logic              hold_en;
  logic              stall;
  logic              bubble_wb;
  logic              capture;

  assign hold_en = (state_q == LU_FWD);

  // EXU GPR operand ports
  for (genvar g = 0; g < NUM_RS; g++) begin : g_exu_rs
    fwd_port_sel #(
      .AW     (GPR_AW),
      .DW     (XLEN),
      .X0_EXCL(1'b1)
    ) u_sel (
      .rs       (EXU_o_rs[g*GPR_AW +: GPR_AW]),
      .mem_rd   (MEM_i_rd),
      .mem_we   (MEM_i_write_gpr),
      .mem_ld   (MEM_i_mem_to_reg),
      .mem_data (MEM_i_ALU_ALUout),
      .wb_rd    (WB_o_rd),
      .wb_we    (WB_o_write_gpr),
      .wb_data  (WB_o_rd_data),
      .hold_en  (hold_en),
      .hold_rd  (hold_rd_q),
      .hold_data(hold_data_q),
      .ld_hit_c (ld_hit[g]),
      .sel_c    (FORWARD_rs_hazard_EXU[g]),
      .data_c   (FORWARD_rs_data_EXU[g*XLEN +: XLEN])
    );
  end

  // CSR operand: load data never targets a CSR, so no hold path
  fwd_port_sel #(
    .AW     (CSR_AW),
    .DW     (XLEN),
    .X0_EXCL(1'b0)
  ) u_csr_sel (
    .rs       (EXU_o_csr_rs),
    .mem_rd   (MEM_i_csr_rd),
    .mem_we   (MEM_i_write_csr),
    .mem_ld   (MEM_i_mem_to_reg),
    .mem_data (MEM_i_ALU_CSR_out),
    .wb_rd    (WB_o_csr_rd),
    .wb_we    (WB_o_write_csr),
    .wb_data  (WB_o_csr_data),
    .hold_en  (1'b0),
    .hold_rd  ('0),
    .hold_data('0),
    .ld_hit_c (csr_ld_hit),
    .sel_c    (FORWARD_csr_hazard_EXU),
    .data_c   (FORWARD_csr_data_EXU)
  );

  // WB -> ID/EX register forwarding
  for (genvar g = 0; g < NUM_RS; g++) begin : g_seg_rs
    logic [GPR_AW-1:0] rs;
    logic              hit;
    assign rs  = IDU_o_rs[g*GPR_AW +: GPR_AW];
    assign hit = WB_o_write_gpr && (rs == WB_o_rd) && (rs != GPR_AW'(REG_X0));
    assign FORWARD_rs_hazard_SEG[g]           = hit;
    assign FORWARD_rs_data_SEG[g*XLEN +: XLEN] = hit ? WB_o_rd_data : '0;
  end

  assign FORWARD_csr_hazard_SEG = WB_o_write_csr && (IDU_o_csr_rs == WB_o_csr_rd);
  assign FORWARD_csr_data_SEG   = FORWARD_csr_hazard_SEG ? WB_o_csr_data : '0;

  assign lu     = (|ld_hit) || csr_ld_hit;
  assign bus_ok = IFU_o_valid && MEM_wready && (MEM_rvalid || !MEM_i_mem_to_reg);

  // Load-use FSM: next state, stall and bubble
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    bubble_wb = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (lu && !flush_i) begin
          state_d = LU_WAIT;
          stall   = 1'b1;
        end else begin
          stall = !bus_ok;
        end
      end
      LU_WAIT: begin
        stall = 1'b1;
        if (flush_i) begin
          state_d   = RUN;
          bubble_wb = !MEM_rvalid;
        end else if (MEM_rvalid) begin
          state_d = LU_FWD;
          capture = 1'b1;
        end
      end
      LU_FWD: begin
        stall = !(IFU_o_valid && MEM_wready);
        if (flush_i || !stall) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Load data hold register; a cleared rd marks it invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_rd_q   <= '0;
    end else if (flush_i) begin
      hold_rd_q <= '0;
    end else if (capture) begin
      hold_data_q <= MEM_o_rdata;
      hold_rd_q   <= MEM_i_rd;
    end
  end

  // Watchdog: counts consecutive stall cycles, saturating
  assign tmo_cnt_d = stall ? ((tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + TMO_W'(1))
                           : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_q || (tmo_cnt_d == TMO_MAX);
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_lu_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q == RUN) && (state_d == LU_WAIT)) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
      if (stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign FORWARD_perf_lu_cnt    = perf_lu_q;
  assign FORWARD_perf_stall_cnt = perf_stall_q;
`else
  // counters not built
`endif

  assign FORWARD_stallIF  = stall;
  assign FORWARD_stallID  = stall;
  assign FORWARD_stallEX  = stall;
  assign FORWARD_stallME  = stall;
  assign FORWARD_stallWB  = stall;
  assign FORWARD_bubbleWB = bubble_wb;
  assign FORWARD_tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed test-plan scenarios plus
// randomized traffic, checked against a behavioural model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IFU_o_valid, MEM_rvalid, MEM_wready, flush_i;
  logic [9:0]  IDU_o_rs, EXU_o_rs;
  logic [1:0]  IDU_o_csr_rs, EXU_o_csr_rs;
  logic [4:0]  MEM_i_rd;
  logic [1:0]  MEM_i_csr_rd;
  logic        MEM_i_write_gpr, MEM_i_write_csr, MEM_i_mem_to_reg;
  logic [31:0] MEM_i_ALU_ALUout, MEM_i_ALU_CSR_out, MEM_o_rdata;
  logic [4:0]  WB_o_rd;
  logic [1:0]  WB_o_csr_rd;
  logic        WB_o_write_gpr, WB_o_write_csr;
  logic [31:0] WB_o_rd_data, WB_o_csr_data;
  logic        stall_if, stall_id, stall_ex, stall_me, stall_wb, bubble_wb;
  logic [1:0]  rs_hz_exu, rs_hz_seg;
  logic [63:0] rs_d_exu, rs_d_seg;
  logic        csr_hz_exu, csr_hz_seg, tmo_err;
  logic [31:0] csr_d_exu, csr_d_seg;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_lu, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(32), .GPR_AW(5), .CSR_AW(2), .NUM_RS(2), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFU_o_valid(IFU_o_valid), .MEM_rvalid(MEM_rvalid), .MEM_wready(MEM_wready),
    .flush_i(flush_i),
    .IDU_o_rs(IDU_o_rs), .IDU_o_csr_rs(IDU_o_csr_rs),
    .EXU_o_rs(EXU_o_rs), .EXU_o_csr_rs(EXU_o_csr_rs),
    .MEM_i_rd(MEM_i_rd), .MEM_i_csr_rd(MEM_i_csr_rd),
    .MEM_i_write_gpr(MEM_i_write_gpr), .MEM_i_write_csr(MEM_i_write_csr),
    .MEM_i_mem_to_reg(MEM_i_mem_to_reg),
    .MEM_i_ALU_ALUout(MEM_i_ALU_ALUout), .MEM_i_ALU_CSR_out(MEM_i_ALU_CSR_out),
    .MEM_o_rdata(MEM_o_rdata),
    .WB_o_rd(WB_o_rd), .WB_o_csr_rd(WB_o_csr_rd),
    .WB_o_write_gpr(WB_o_write_gpr), .WB_o_write_csr(WB_o_write_csr),
    .WB_o_rd_data(WB_o_rd_data), .WB_o_csr_data(WB_o_csr_data),
    .FORWARD_stallIF(stall_if), .FORWARD_stallID(stall_id), .FORWARD_stallEX(stall_ex),
    .FORWARD_stallME(stall_me), .FORWARD_stallWB(stall_wb),
    .FORWARD_bubbleWB(bubble_wb),
    .FORWARD_rs_hazard_EXU(rs_hz_exu), .FORWARD_rs_data_EXU(rs_d_exu),
    .FORWARD_csr_hazard_EXU(csr_hz_exu), .FORWARD_csr_data_EXU(csr_d_exu),
    .FORWARD_rs_hazard_SEG(rs_hz_seg), .FORWARD_rs_data_SEG(rs_d_seg),
    .FORWARD_csr_hazard_SEG(csr_hz_seg), .FORWARD_csr_data_SEG(csr_d_seg),
`ifdef FWD_PERF_CNT_EN
    .FORWARD_perf_lu_cnt(perf_lu), .FORWARD_perf_stall_cnt(perf_stall),
`endif
    .FORWARD_tmo_err(tmo_err)
  );

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic [1:0]  rs_hz;
    logic [63:0] rs_d;
    logic        csr_hz;
    logic [31:0] csr_d;
    logic [1:0]  seg_hz;
    logic [63:0] seg_d;
    logic        csr_seg_hz;
    logic [31:0] csr_seg_d;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Model state: waiting for load data, forwarding held data, watchdog
  bit          m_wait, m_fwd, m_err;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  int          m_cnt;

  task automatic model_reset();
    m_wait = 0; m_fwd = 0; m_err = 0; m_hold_rd = '0; m_hold_data = '0; m_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Compute the expected response for the inputs currently applied, queue it,
  // then advance the model across the clock edge.
  task automatic step();
    exp_t        e;
    bit          lu, bus_ok, nw, nf, ne;
    logic [4:0]  r, nhr;
    logic [31:0] nhd;
    int          nc;
    if (!rst_n) model_reset();
    e  = '0;
    lu = 0;
    for (int i = 0; i < 2; i++) begin
      r = EXU_o_rs[i*5 +: 5];
      if (r != 0) begin
        if (MEM_i_write_gpr && MEM_i_mem_to_reg && r == MEM_i_rd) lu = 1;
        if (m_fwd && r == m_hold_rd) begin
          e.rs_hz[i] = 1; e.rs_d[i*32 +: 32] = m_hold_data;
        end else if (MEM_i_write_gpr && !MEM_i_mem_to_reg && r == MEM_i_rd) begin
          e.rs_hz[i] = 1; e.rs_d[i*32 +: 32] = MEM_i_ALU_ALUout;
        end else if (WB_o_write_gpr && r == WB_o_rd) begin
          e.rs_hz[i] = 1; e.rs_d[i*32 +: 32] = WB_o_rd_data;
        end
      end
      r = IDU_o_rs[i*5 +: 5];
      if (r != 0 && WB_o_write_gpr && r == WB_o_rd) begin
        e.seg_hz[i] = 1; e.seg_d[i*32 +: 32] = WB_o_rd_data;
      end
    end
    if (MEM_i_write_csr && EXU_o_csr_rs == MEM_i_csr_rd) begin
      if (MEM_i_mem_to_reg) lu = 1;
      else begin e.csr_hz = 1; e.csr_d = MEM_i_ALU_CSR_out; end
    end
    if (!e.csr_hz && WB_o_write_csr && EXU_o_csr_rs == WB_o_csr_rd) begin
      e.csr_hz = 1; e.csr_d = WB_o_csr_data;
    end
    if (WB_o_write_csr && IDU_o_csr_rs == WB_o_csr_rd) begin
      e.csr_seg_hz = 1; e.csr_seg_d = WB_o_csr_data;
    end

    bus_ok = IFU_o_valid && MEM_wready && (MEM_rvalid || !MEM_i_mem_to_reg);
    if (m_wait)     e.stall = 1;
    else if (m_fwd) e.stall = !(IFU_o_valid && MEM_wready);
    else            e.stall = (lu && !flush_i) ? 1'b1 : !bus_ok;

    nw = m_wait; nf = m_fwd; nhr = m_hold_rd; nhd = m_hold_data;
    if (flush_i) begin
      e.bubble = m_wait && !MEM_rvalid;
      nw = 0; nf = 0; nhr = '0;
    end else if (m_wait) begin
      if (MEM_rvalid) begin nw = 0; nf = 1; nhr = MEM_i_rd; nhd = MEM_o_rdata; end
    end else if (m_fwd) begin
      if (!e.stall) nf = 0;
    end else if (lu) begin
      nw = 1;
    end
    e.err = m_err;
    nc = e.stall ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
    ne = m_err || (nc == 15);
    exp_q.push_back(e);

    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_wait = nw; m_fwd = nf; m_hold_rd = nhr; m_hold_data = nhd; m_cnt = nc; m_err = ne;
    end
    #1;
  endtask

  task automatic idle_inputs();
    IFU_o_valid = 1; MEM_wready = 1; MEM_rvalid = 0; flush_i = 0;
    IDU_o_rs = '0; IDU_o_csr_rs = '0; EXU_o_rs = '0; EXU_o_csr_rs = '0;
    MEM_i_rd = '0; MEM_i_csr_rd = '0; MEM_i_write_gpr = 0; MEM_i_write_csr = 0;
    MEM_i_mem_to_reg = 0; MEM_i_ALU_ALUout = '0; MEM_i_ALU_CSR_out = '0; MEM_o_rdata = '0;
    WB_o_rd = '0; WB_o_csr_rd = '0; WB_o_write_gpr = 0; WB_o_write_csr = 0;
    WB_o_rd_data = '0; WB_o_csr_data = '0;
  endtask

  task automatic setup_load(input logic [4:0] rd, input int port);
    idle_inputs();
    MEM_i_rd = rd; MEM_i_write_gpr = 1; MEM_i_mem_to_reg = 1;
    EXU_o_rs[port*5 +: 5] = rd;
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", {59'd0, stall_if, stall_id, stall_ex, stall_me, stall_wb}, {59'd0, {5{e.stall}}});
        chk("bubbleWB", {63'd0, bubble_wb}, {63'd0, e.bubble});
        chk("rs_hazard_EXU", {62'd0, rs_hz_exu}, {62'd0, e.rs_hz});
        chk("rs_data_EXU", rs_d_exu, e.rs_d);
        chk("csr_hazard_EXU", {63'd0, csr_hz_exu}, {63'd0, e.csr_hz});
        chk("csr_data_EXU", {32'd0, csr_d_exu}, {32'd0, e.csr_d});
        chk("rs_hazard_SEG", {62'd0, rs_hz_seg}, {62'd0, e.seg_hz});
        chk("rs_data_SEG", rs_d_seg, e.seg_d);
        chk("csr_hazard_SEG", {63'd0, csr_hz_seg}, {63'd0, e.csr_seg_hz});
        chk("csr_data_SEG", {32'd0, csr_d_seg}, {32'd0, e.csr_seg_d});
        chk("tmo_err", {63'd0, tmo_err}, {63'd0, e.err});
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1;

    // ALU chain
    idle_inputs();
    MEM_i_rd = 5; MEM_i_write_gpr = 1; MEM_i_ALU_ALUout = 32'h1234; EXU_o_rs[4:0] = 5;
    step();

    // Load-use with three wait cycles
    setup_load(5'd7, 1);
    step(); step(); step();
    MEM_rvalid = 1; MEM_o_rdata = 32'hDEADBEEF;
    step();
    MEM_rvalid = 0;
    step();
    idle_inputs();
    step();

    // MEM ALU over WB, then x0 in MEM falls back to WB
    idle_inputs();
    MEM_i_rd = 3; MEM_i_write_gpr = 1; MEM_i_ALU_ALUout = 32'hA;
    WB_o_rd = 3; WB_o_write_gpr = 1; WB_o_rd_data = 32'hB; EXU_o_rs[4:0] = 3;
    step();
    MEM_i_rd = 0;
    step();

    // Flush while waiting for load data
    setup_load(5'd12, 0);
    step(); step();
    flush_i = 1;
    step();
    idle_inputs();
    EXU_o_rs[4:0] = 12;
    step(); step();

    // Asynchronous reset during the wait
    setup_load(5'd6, 1);
    step(); step();
    #1 rst_n = 0;
    step();
    rst_n = 1;
    idle_inputs();
    EXU_o_rs[9:5] = 6;
    step();

    // SEG path, GPR and CSR (CSR index 0 is a real register)
    idle_inputs();
    WB_o_rd = 9; WB_o_write_gpr = 1; WB_o_rd_data = 32'h55; IDU_o_rs[4:0] = 9;
    WB_o_csr_rd = 0; WB_o_write_csr = 1; WB_o_csr_data = 32'h77;
    step();
    WB_o_rd = 0; IDU_o_rs[4:0] = 0;
    step();

    // Randomized traffic over a small index space to provoke hits
    for (int n = 0; n < 600; n++) begin
      IFU_o_valid = ($urandom_range(0, 9) != 0);
      MEM_wready  = ($urandom_range(0, 9) != 0);
      MEM_rvalid  = ($urandom_range(0, 9) < 4);
      flush_i     = ($urandom_range(0, 19) == 0);
      IDU_o_rs    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      EXU_o_rs    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      IDU_o_csr_rs = 2'($urandom_range(0, 3));
      EXU_o_csr_rs = 2'($urandom_range(0, 3));
      MEM_i_rd     = 5'($urandom_range(0, 3));
      MEM_i_csr_rd = 2'($urandom_range(0, 3));
      MEM_i_write_gpr  = ($urandom_range(0, 3) != 0);
      MEM_i_write_csr  = ($urandom_range(0, 3) == 0);
      MEM_i_mem_to_reg = ($urandom_range(0, 9) < 3);
      MEM_i_ALU_ALUout  = $urandom;
      MEM_i_ALU_CSR_out = $urandom;
      MEM_o_rdata       = $urandom;
      WB_o_rd      = 5'($urandom_range(0, 3));
      WB_o_csr_rd  = 2'($urandom_range(0, 3));
      WB_o_write_gpr = ($urandom_range(0, 3) != 0);
      WB_o_write_csr = ($urandom_range(0, 3) == 0);
      WB_o_rd_data  = $urandom;
      WB_o_csr_data = $urandom;
      step();
    end

    // Watchdog from a clean reset: 15 stalls saturate, error stays sticky
    idle_inputs();
    #1 rst_n = 0;
    step();
    rst_n = 1;
    IFU_o_valid = 0;
    repeat (16) step();
    IFU_o_valid = 1;
    repeat (3) step();

    begin
      int budget = 5;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
